// File: rtl/sequence_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package sequence_gen_pkg;

  localparam int PAT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/sequence_gen_shifter.sv
// Captures a pattern and walks a bit index from len-1 down to 0; out is registered.
// One cycle from load/shift to out; no backpressure, caller sequences load/shift/restart.
module sequence_gen_shifter #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             restart,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             last
);

  localparam int IDX_W = $clog2(PAT_W);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ld_idx;
  logic [IDX_W-1:0] rs_idx;
  logic [IDX_W-1:0] dec_idx;

  always_comb begin
    ld_idx  = IDX_W'(len - LEN_W'(1));
    rs_idx  = IDX_W'(len_q - LEN_W'(1));
    dec_idx = idx_q - IDX_W'(1);
  end

  // idx_q always names the bit currently on bit_out
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      bit_out <= 1'b0;
    end else if (load) begin
      pat_q   <= pattern;
      len_q   <= len;
      idx_q   <= ld_idx;
      bit_out <= pattern[ld_idx];
    end else if (restart) begin
      idx_q   <= rs_idx;
      bit_out <= pat_q[rs_idx];
    end else if (shift) begin
      idx_q   <= dec_idx;
      bit_out <= pat_q[dec_idx];
    end else begin
      bit_out <= 1'b0;
    end
  end

  assign last = (idx_q == '0);

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern generator, MSB-first, first bit one cycle after start; start ignored while busy.
// Optional SEQ_GEN_REPEAT_EN adds reps input to send the pattern reps times back-to-back.
module sequence_gen
  import sequence_gen_pkg::*;
#(
  parameter  int PAT_W = PAT_W_DEF,
  localparam int LEN_W = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
`ifdef SEQ_GEN_REPEAT_EN
  input  logic [3:0]       reps,
`endif
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_eff;
  logic             load;
  logic             shift;
  logic             restart;
  logic             last;
  logic             more;
  logic             valid_nxt;
  logic             busy_nxt;
  logic             done_nxt;

  always_comb len_eff = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;

`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0] reps_left;

  always_ff @(posedge clk) begin
    if (rst) begin
      reps_left <= '0;
    end else if (state == IDLE && start) begin
      reps_left <= (reps == 4'd0) ? 4'd0 : reps - 4'd1;
    end else if (restart) begin
      reps_left <= reps_left - 4'd1;
    end
  end

  assign more = (reps_left != 4'd0);
`else
  assign more = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? FINISH : SEND;
      SEND:    if (last && !more) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    shift   = 1'b0;
    restart = 1'b0;
    case (state)
      IDLE: load = start && (len != '0);
      SEND: begin
        if (last) restart = more;
        else      shift   = 1'b1;
      end
      default: ;
    endcase
    valid_nxt = (state_nxt == SEND);
    busy_nxt  = (state_nxt == SEND);
    done_nxt  = (state_nxt == FINISH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      valid <= valid_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  sequence_gen_shifter #(
    .PAT_W(PAT_W),
    .LEN_W(LEN_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .restart (restart),
    .pattern (pattern),
    .len     (len_eff),
    .bit_out (out),
    .last    (last)
  );

endmodule

// File: tb/tb_sequence_gen.sv
// Bench for sequence_gen: table-driven transfers scored per cycle, plus reset/abort/ignore corners.
module tb_sequence_gen;

  typedef struct packed {
    logic out;
    logic valid;
    logic busy;
    logic done;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } exp_t;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] len;
    int         n;
    logic [7:0] seq;  // transmitted bits, first bit in seq[7]
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;
`ifdef SEQ_GEN_REPEAT_EN
  logic [3:0] reps;
`endif

  always #5 clk = ~clk;

  sequence_gen #(.PAT_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
`ifdef SEQ_GEN_REPEAT_EN
    .reps    (reps),
`endif
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic       det_clr;
  logic [3:0] det_sr;
  int         det_hits;
  int         det_pos;
  int         vbits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push(input obs_t o, input string tag);
    exp_t e;
    e.o   = o;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain(input int max, input string name);
    int k = 0;
    while (sb.size() > 0 && k < max) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got %0d records left want 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard pop plus a 1011 loopback detector fed by out/valid
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, {28'd0, out, valid, busy, done}, {28'd0, e.o});
    end
    if (det_clr) begin
      det_sr   = 4'd0;
      det_hits = 0;
      det_pos  = 0;
      vbits    = 0;
    end else if (valid) begin
      vbits++;
      if ({det_sr[2:0], out} == 4'b1011) begin
        det_hits++;
        det_pos = vbits;
      end
      det_sr = {det_sr[2:0], out};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    vt[0] = '{8'b0000_1011, 4'd4,  4, 8'b1011_0000};
    vt[1] = '{8'hA5,        4'd8,  8, 8'b1010_0101};
    vt[2] = '{8'hFF,        4'd1,  1, 8'b1000_0000};
    vt[3] = '{8'h3C,        4'd12, 8, 8'b0011_1100};
    vt[4] = '{8'h02,        4'd2,  2, 8'b1000_0000};
    vt[5] = '{8'h55,        4'd0,  0, 8'b0000_0000};
    vt[6] = '{8'h80,        4'd8,  8, 8'b1000_0000};

    // Reset with start held high: reset must win
    rst     = 1'b1;
    start   = 1'b1;
    pattern = 8'h0B;
    len     = 4'd4;
    det_clr = 1'b1;
`ifdef SEQ_GEN_REPEAT_EN
    reps    = 4'd1;
`endif
    repeat (2) @(negedge clk);
    check("rst_outputs", {28'd0, out, valid, busy, done}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {28'd0, out, valid, busy, done}, 32'd0);

    // Back-to-back transfers at the minimum len+2 spacing
    for (int i = 0; i < 7; i++) begin
      if (i == 0) det_clr = 1'b0;
      if (i == 1) begin
        check("loop_det_hits", det_hits, 1);
        check("loop_det_pos", det_pos, 4);
      end
      for (int k = 0; k < vt[i].n; k++)
        push(obs_t'({vt[i].seq[7-k], 3'b110}), $sformatf("v%0d_bit%0d", i, k));
      push(obs_t'(4'b0001), $sformatf("v%0d_done", i));
      push(obs_t'(4'b0000), $sformatf("v%0d_idle", i));
      start   = 1'b1;
      pattern = vt[i].pat;
      len     = vt[i].len;
      @(negedge clk);
      start = 1'b0;
      repeat (vt[i].n + 1) @(negedge clk);
    end
    drain(20, "vec_drain");

    // Start re-pulsed through SEND and FINISH with another pattern is ignored
    for (int k = 0; k < 8; k++)
      push(obs_t'({k == 0 || k == 1 || k == 3 || k == 6, 3'b110}), $sformatf("ign_bit%0d", k));
    push(obs_t'(4'b0001), "ign_done");
    push(obs_t'(4'b0000), "ign_idle0");
    push(obs_t'(4'b0000), "ign_idle1");
    start   = 1'b1;
    pattern = 8'hD2;
    len     = 4'd8;
    @(negedge clk);
    pattern = 8'hFF;
    len     = 4'd3;
    repeat (9) @(negedge clk);
    start = 1'b0;
    drain(20, "ign_drain");

    // Reset during the second bit aborts with no done pulse
    push(obs_t'(4'b1110), "abort_bit0");
    push(obs_t'(4'b1110), "abort_bit1");
    for (int k = 0; k < 10; k++)
      push(obs_t'(4'b0000), $sformatf("abort_quiet%0d", k));
    start   = 1'b1;
    pattern = 8'hFF;
    len     = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain(20, "abort_drain");

`ifdef SEQ_GEN_REPEAT_EN
    // Two repetitions of 101 with no gap, then one done
    push(obs_t'(4'b1110), "rep_b0");
    push(obs_t'(4'b0110), "rep_b1");
    push(obs_t'(4'b1110), "rep_b2");
    push(obs_t'(4'b1110), "rep_b3");
    push(obs_t'(4'b0110), "rep_b4");
    push(obs_t'(4'b1110), "rep_b5");
    push(obs_t'(4'b0001), "rep_done");
    push(obs_t'(4'b0000), "rep_idle");
    start   = 1'b1;
    pattern = 8'b0000_0101;
    len     = 4'd3;
    reps    = 4'd2;
    @(negedge clk);
    start = 1'b0;
    reps  = 4'd1;
    drain(20, "rep_drain");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sequence_gen.md
SEQUENCE_GEN -- requirements
Module: sequence_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 8, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have derived local parameter LEN_W = $clog2(PAT_W)+1, the width of the length field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to transmit; sampled only in IDLE.
REQ-006 SHALL have port pattern, input, PAT_W bits: bits to send; captured on start acceptance.
REQ-007 SHALL have port len, input, LEN_W bits: number of bits to send; captured with pattern.
REQ-008 SHALL have port out, output, 1 bit: serial data stream, the drive for a sequence_detect input.
REQ-009 SHALL have port valid, output, 1 bit: high when out carries a pattern bit.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after acceptance until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse at completion.

Function
REQ-012 SHALL implement FSM states IDLE, SEND, FINISH.
REQ-013 SHALL accept start only in IDLE; IDLE + start=1 -> capture pattern/len; next state SEND, or FINISH if len==0.
REQ-014 SHALL ignore start in SEND and FINISH, with no queuing.
REQ-015 SHALL send the bits MSB-first from pattern[len-1] down to pattern[0], one bit per cycle; the first bit appears on out the cycle after acceptance (latency 1).
REQ-016 SHALL clamp len > PAT_W to PAT_W.
REQ-017 SHALL hold valid=1 and busy=1 for exactly len cycles in SEND.
REQ-018 SHALL pulse done=1 for one cycle in FINISH, with busy=0, valid=0, out=0, and return to IDLE on the next cycle.
REQ-019 SHALL treat len==0 as an empty transfer: no valid cycles and a done pulse 1 cycle after acceptance.
REQ-020 SHALL force out=0 whenever valid=0.
REQ-021 SHALL register all outputs, with no combinational path from inputs to outputs.
REQ-022 SHALL allow a new start to be accepted in the IDLE cycle directly after FINISH, giving a minimum start-to-start spacing of len+2 cycles.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, go to IDLE with out=0, valid=0, busy=0, done=0 and clear the bit counter and captured registers.
REQ-024 SHALL abort a transfer when rst is asserted mid-transfer; no done pulse is produced for the aborted transfer.
REQ-025 SHALL give rst priority over start in the same cycle.

Configuration
REQ-026 SHALL, with macro SEQ_GEN_REPEAT_EN defined, add input reps[3:0], captured at acceptance, and send the pattern reps times back-to-back with no gap cycles; reps==0 is treated as 1.
REQ-027 SHALL, with SEQ_GEN_REPEAT_EN defined, produce a single done pulse after the final repetition.
REQ-028 SHALL, without SEQ_GEN_REPEAT_EN, have no reps port and send each pattern exactly once.

Structure
REQ-029 SHALL take the state enum type (IDLE/SEND/FINISH) and the PAT_W default constant from shared package sequence_gen_pkg.
REQ-030 SHALL place the bit counter and output mux in one sub-module, sequence_gen_shifter (load, shift enable, current bit out, last-bit flag); the FSM stays in sequence_gen.

Verification
REQ-031 SHALL verify: reset, then pattern=8'b0000_1011, len=4, start 1 cycle -> out=1,0,1,1 on cycles 1-4 with valid high, then done on cycle 5.
REQ-032 SHALL verify: loopback of out into sequence_detect with pattern 1011 -> detector out asserts once, aligned to the 4th bit.
REQ-033 SHALL verify: len=0 with start -> valid never high, done pulses exactly 1 cycle after acceptance.
REQ-034 SHALL verify: start pulsed again during SEND with a different pattern -> ignored; first pattern completes unchanged.
REQ-035 SHALL verify: rst asserted on the 2nd bit of an 8-bit transfer -> next cycle out=0, busy=0, and no done pulse.
REQ-036 SHALL verify: with SEQ_GEN_REPEAT_EN, pattern=3'b101, len=3, reps=2 -> out=1,0,1,1,0,1 over 6 consecutive valid cycles, then a single done pulse.
